// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: state type, default code constants and the parity helper
// shared by the convolutional encoder framer and its shift-register core.
package conv_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam int         K_DEF  = 3;
  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  // Widest constraint length the parity helper accepts.
  localparam int MAX_K = 16;

  function automatic logic parity(input logic [MAX_K-1:0] v, input logic [MAX_K-1:0] g);
    return ^(v & g);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: K-1 bit encoder shift register with shift/clear control and
// a combinational rate-1/2 code symbol for the bit currently presented on d.
module conv_enc_core
  import conv_enc_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift,
  input  logic       clear,
  input  logic       d,
  output logic [1:0] sym
);

  logic [K-2:0] sr;
  logic [K-1:0] v;

  // v = {d, sr[0], ..., sr[K-2]}: the newest history bit sits next to d.
  always_comb begin
    v[K-1] = d;
    for (int i = 0; i < K-1; i++) begin
      v[K-2-i] = sr[i];
    end
  end

  assign sym = {parity(MAX_K'(v), MAX_K'(G0)), parity(MAX_K'(v), MAX_K'(G1))};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift) begin
      sr <= (K-1)'({sr, d});
    end
  end

endmodule

// File: rtl/conv_enc_framer.sv
// conv_enc_framer: framed rate-1/2 convolutional encoder, one symbol per bit.
// Define ENC_TAIL_EN for K-1 zero tail bits per frame; otherwise frames run back to back.
module conv_enc_framer
  import conv_enc_pkg::*;
#(
  parameter int           FRAME_LEN = 16,
  parameter int           K         = K_DEF,
  parameter logic [K-1:0] G0        = G0_DEF,
  parameter logic [K-1:0] G1        = G1_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        d_in,
  output logic        ready_o,
  output logic        valid_o,
  output logic [1:0]  d_out,
  output logic        sof_o,
  output logic        eof_o,
  output logic [15:0] frame_ct_o
);

  // state | meaning
  // IDLE  | waiting for the first data bit of a frame
  // DATA  | frame in progress, bit_ct data bits accepted so far
  // TAIL  | flushing K-1 zero bits, input held off

  localparam int             BCW      = $clog2(FRAME_LEN + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_LEN - 1);

  state_t         state, state_n;
  logic [BCW-1:0] bit_ct, bit_ct_n;
  logic           accept, enc_d, shift, clear, emit, sof_n, eof_n;
  logic [1:0]     sym;

`ifdef ENC_TAIL_EN
  localparam int             TCW       = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [TCW-1:0] TAIL_LAST = TCW'(K - 2);

  logic [TCW-1:0] tail_ct, tail_ct_n;

  assign ready_o = (state != TAIL);
`else
  assign ready_o = 1'b1;
`endif

  assign accept = enable_i && ready_o;

  always_comb begin
    state_n  = state;
    bit_ct_n = bit_ct;
    enc_d    = d_in;
    shift    = 1'b0;
    clear    = 1'b0;
    emit     = 1'b0;
    sof_n    = 1'b0;
    eof_n    = 1'b0;
`ifdef ENC_TAIL_EN
    tail_ct_n = tail_ct;
`endif
    case (state)
      IDLE, DATA: begin
        if (accept) begin
          shift    = 1'b1;
          emit     = 1'b1;
          sof_n    = (state == IDLE);
          bit_ct_n = bit_ct + BCW'(1);
          state_n  = DATA;
          if (bit_ct == LAST_BIT) begin
`ifdef ENC_TAIL_EN
            state_n   = TAIL;
            tail_ct_n = '0;
`else
            eof_n    = 1'b1;
            bit_ct_n = '0;
            state_n  = IDLE;
`endif
          end
        end
      end
`ifdef ENC_TAIL_EN
      TAIL: begin
        enc_d     = 1'b0;
        shift     = 1'b1;
        emit      = 1'b1;
        tail_ct_n = tail_ct + TCW'(1);
        if (tail_ct == TAIL_LAST) begin
          eof_n    = 1'b1;
          clear    = 1'b1;
          bit_ct_n = '0;
          state_n  = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  conv_enc_core #(.K(K), .G0(G0), .G1(G1)) u_core (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .clear (clear),
    .d     (enc_d),
    .sym   (sym)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_ct     <= '0;
      valid_o    <= 1'b0;
      d_out      <= '0;
      sof_o      <= 1'b0;
      eof_o      <= 1'b0;
      frame_ct_o <= '0;
    end else begin
      state   <= state_n;
      bit_ct  <= bit_ct_n;
      valid_o <= emit;
      sof_o   <= sof_n;
      eof_o   <= eof_n;
      if (emit) begin
        d_out <= sym;
      end
      if (eof_n) begin
        frame_ct_o <= frame_ct_o + 16'd1;
      end
    end
  end

`ifdef ENC_TAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_ct <= '0;
    end else begin
      tail_ct <= tail_ct_n;
    end
  end
`endif

endmodule

// File: tb/tb_conv_enc_framer.sv
// tb_conv_enc_framer: table vectors, directed corner sequences and random
// stimulus against a frame-level reference encoder.
module tb_conv_enc_framer;

  localparam int         FL  = 4;
  localparam int         K   = 3;
  localparam logic [2:0] G0  = 3'b111;
  localparam logic [2:0] G1  = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        d_in = 1'b0;
  logic        ready_o, valid_o, sof_o, eof_o;
  logic [1:0]  d_out;
  logic [15:0] frame_ct_o;

  logic        en16 = 1'b0;
  logic        d16 = 1'b0;
  logic        rdy16, v16, sof16, eof16;
  logic [1:0]  do16;
  logic [15:0] fct16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_enc_framer #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in),
    .ready_o(ready_o), .valid_o(valid_o), .d_out(d_out),
    .sof_o(sof_o), .eof_o(eof_o), .frame_ct_o(frame_ct_o)
  );

  conv_enc_framer #(.FRAME_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .enable_i(en16), .d_in(d16),
    .ready_o(rdy16), .valid_o(v16), .d_out(do16),
    .sof_o(sof16), .eof_o(eof16), .frame_ct_o(fct16)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: history of bits since the encoder was last zeroed.
  bit m_ctx[$];
  int m_cnt, m_tail_left, m_frames;

  task automatic model_reset();
    m_ctx.delete();
    m_cnt       = 0;
    m_tail_left = 0;
    m_frames    = 0;
  endtask

  function automatic logic [1:0] model_sym(input bit b);
    bit p1, p0, tap;
    p1 = 1'b0;
    p0 = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (j == 0) tap = b;
      else if (m_ctx.size() >= j) tap = m_ctx[m_ctx.size() - j];
      else tap = 1'b0;
      p1 ^= G0[K-1-j] & tap;
      p0 ^= G1[K-1-j] & tap;
    end
    m_ctx.push_back(b);
    if (m_ctx.size() > K-1) void'(m_ctx.pop_front());
    return {p1, p0};
  endfunction

  logic [1:0] obs_q[$];

  // One clock: drive at a falling edge, predict, check at the next falling edge.
  task automatic cycle(input logic en, input logic d);
    logic       ev, es, ee, er;
    logic [1:0] ed;
    enable_i = en;
    d_in     = d;
    er = (m_tail_left == 0);
    chk("ready", int'(ready_o), int'(er));
    ev = 1'b0; es = 1'b0; ee = 1'b0; ed = 2'b00;
    if (m_tail_left > 0) begin
      ed = model_sym(1'b0);
      ev = 1'b1;
      m_tail_left--;
      if (m_tail_left == 0) begin
        ee = 1'b1;
        m_frames++;
        m_ctx.delete();
      end
    end else if (en) begin
      ed = model_sym(d);
      ev = 1'b1;
      m_cnt++;
      es = (m_cnt == 1);
      if (m_cnt == FL) begin
        m_cnt = 0;
`ifdef ENC_TAIL_EN
        m_tail_left = K - 1;
`else
        ee = 1'b1;
        m_frames++;
`endif
      end
    end
    @(negedge clk);
    chk("valid", int'(valid_o), int'(ev));
    chk("sof", int'(sof_o), int'(es));
    chk("eof", int'(eof_o), int'(ee));
    chk("frame_ct", int'(frame_ct_o), m_frames % 65536);
    if (ev) chk("d_out", int'(d_out), int'(ed));
    if (valid_o) obs_q.push_back(d_out);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    enable_i = 1'b0;
    d_in     = 1'b0;
    en16     = 1'b0;
    d16      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_q.delete();
  endtask

  typedef struct {
    logic       en;
    logic       d;
    logic       rdy;
    logic       v;
    logic [1:0] dout;
    logic       sof;
    logic       eof;
    int         fct;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic d, input logic rdy, input logic v,
                     input logic [1:0] dout, input logic sof, input logic eof, input int fct);
    vec_t t;
    t.en = en; t.d = d; t.rdy = rdy; t.v = v; t.dout = dout;
    t.sof = sof; t.eof = eof; t.fct = fct;
    tbl.push_back(t);
  endtask

  initial begin
    logic [1:0] exp_syms[$];
    logic       last_eof;
    int         n16;

    model_reset();

`ifdef ENC_TAIL_EN
    // data 1,0,1,1 then enable held high through the tail
    add(1, 1, 1, 1, 2'b11, 1, 0, 0);
    add(1, 0, 1, 1, 2'b10, 0, 0, 0);
    add(1, 1, 1, 1, 2'b00, 0, 0, 0);
    add(1, 1, 1, 1, 2'b01, 0, 0, 0);
    add(1, 1, 0, 1, 2'b01, 0, 0, 0);
    add(1, 1, 0, 1, 2'b11, 0, 1, 1);
    add(1, 1, 1, 1, 2'b11, 1, 0, 1);
    add(0, 0, 1, 0, 2'b00, 0, 0, 1);
`else
    add(1, 1, 1, 1, 2'b11, 1, 0, 0);
    add(1, 0, 1, 1, 2'b10, 0, 0, 0);
    add(1, 1, 1, 1, 2'b00, 0, 0, 0);
    add(1, 1, 1, 1, 2'b01, 0, 1, 1);
    add(1, 0, 1, 1, 2'b01, 1, 0, 1);
    add(1, 0, 1, 1, 2'b11, 0, 0, 1);
    add(1, 0, 1, 1, 2'b00, 0, 0, 1);
    add(1, 0, 1, 1, 2'b00, 0, 1, 2);
    add(0, 0, 1, 0, 2'b00, 0, 0, 2);
`endif

    do_reset();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_d_out", int'(d_out), 0);
    chk("rst_sof", int'(sof_o), 0);
    chk("rst_eof", int'(eof_o), 0);
    chk("rst_frame_ct", int'(frame_ct_o), 0);
    chk("rst_ready", int'(ready_o), 1);

    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d_ready", i), int'(ready_o), int'(tbl[i].rdy));
      cycle(tbl[i].en, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), int'(valid_o), int'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("tbl%0d_d_out", i), int'(d_out), int'(tbl[i].dout));
      chk($sformatf("tbl%0d_sof", i), int'(sof_o), int'(tbl[i].sof));
      chk($sformatf("tbl%0d_eof", i), int'(eof_o), int'(tbl[i].eof));
      chk($sformatf("tbl%0d_frame_ct", i), int'(frame_ct_o), tbl[i].fct);
    end

    // Gapped input: enable 1,0,0,1,1,0,1 carrying bits 1,0,1,1.
    do_reset();
    cycle(1, 1); cycle(0, 1); cycle(0, 0); cycle(1, 0);
    cycle(1, 1); cycle(0, 0); cycle(1, 1);
    repeat (3) cycle(0, 0);
`ifdef ENC_TAIL_EN
    exp_syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
`else
    exp_syms = '{2'b11, 2'b10, 2'b00, 2'b01};
`endif
    chk("gap_count", obs_q.size(), exp_syms.size());
    foreach (exp_syms[i]) begin
      if (i < obs_q.size()) chk($sformatf("gap_sym%0d", i), int'(obs_q[i]), int'(exp_syms[i]));
    end

    // Reset inside a frame (inside the tail when tail flush is built in).
    do_reset();
    cycle(1, 1); cycle(1, 0); cycle(1, 1); cycle(1, 1);
`ifdef ENC_TAIL_EN
    repeat (2) cycle(0, 0);
    cycle(1, 1); cycle(1, 1); cycle(1, 1); cycle(1, 1);
`else
    cycle(1, 1); cycle(1, 1);
`endif
    chk("pre_rst_frame_ct", int'(frame_ct_o), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_d_out", int'(d_out), 0);
    chk("mid_rst_sof", int'(sof_o), 0);
    chk("mid_rst_eof", int'(eof_o), 0);
    chk("mid_rst_frame_ct", int'(frame_ct_o), 0);
    chk("mid_rst_ready", int'(ready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(1, 1);
    chk("post_rst_d_out", int'(d_out), 3);
    chk("post_rst_sof", int'(sof_o), 1);
    repeat (FL + 2) cycle(0, 0);

    // Random enable/data against the reference encoder.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 99) < 70), logic'($urandom_range(0, 1)));
    end
    repeat (K + 1) cycle(0, 0);

    // Impulse on a 16-bit frame.
    do_reset();
    obs_q.delete();
    last_eof = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en16 = (i < 16);
      d16  = (i == 0);
      @(negedge clk);
      if (v16) begin
        obs_q.push_back(do16);
        last_eof = eof16;
      end
    end
    en16 = 1'b0;
`ifdef ENC_TAIL_EN
    n16 = 18;
`else
    n16 = 16;
`endif
    chk("imp_count", obs_q.size(), n16);
    for (int i = 0; i < n16; i++) begin
      if (i < obs_q.size())
        chk($sformatf("imp_sym%0d", i), int'(obs_q[i]),
            (i == 0) ? 3 : (i == 1) ? 2 : (i == 2) ? 3 : 0);
    end
    chk("imp_last_eof", int'(last_eof), 1);
    chk("imp_frame_ct", int'(fct16), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_enc_framer.md
# conv_enc_framer

Framed rate-1/2 convolutional encoder: the transmit-side counterpart of the team's Viterbi decoder. It accepts one data bit per enabled cycle, emits one 2-bit code symbol per bit, and terminates each frame of FRAME_LEN bits with K-1 zero tail bits, so the decoder's traceback starts and ends in state 0. It sits ahead of the channel/error-injection stage in the tx/rx loopback top.

## Interface
- FRAME_LEN, 16: data bits per frame (≥1)
- K, 3: constraint length (shift register holds K-1 bits)
- G0, 3'b111: generator for d_out[1], MSB applies to the current bit
- G1, 3'b101: generator for d_out[0]

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- enable_i  in  1  d_in valid this cycle
- d_in  in  1  data bit
- ready_o  out  1  bit accepted when enable_i && ready_o
- valid_o  out  1  d_out holds a new symbol this cycle
- d_out  out  2  code symbol {parity G0, parity G1}
- sof_o  out  1  qualifies the first symbol of a frame
- eof_o  out  1  qualifies the last symbol of a frame
- frame_ct_o  out  16  completed-frame count

## Operation
- Shift register sr[K-2:0], sr[0] newest. Vector v = {d, sr[0], …, sr[K-2]}; d_out[1] = ^(v & G0), d_out[0] = ^(v & G1). Each encoded bit shifts d into sr[0].
- FSM states:
  - IDLE: sr=0, bit_ct=0. An accepted bit emits a symbol with sof_o=1, sets bit_ct=1, goes to DATA (or TAIL if FRAME_LEN=1).
  - DATA: each accepted bit emits a symbol and increments bit_ct; accepting bit FRAME_LEN goes to TAIL, tail_ct=0.
  - TAIL: ready_o=0 and enable_i/d_in are ignored. Encodes d=0 every cycle without waiting for enable. tail_ct counts to K-1. The last tail symbol has eof_o=1, frame_ct_o increments, sr clears, state returns to IDLE.
- ready_o = (state != TAIL), decoded from the state register.
- Idle gaps (enable_i low in IDLE/DATA): valid_o=0; sr, bit_ct and state hold.
- sof_o and eof_o are only meaningful while valid_o=1; both are 0 otherwise.
- frame_ct_o wraps 65535→0.
- bit_ct width is $clog2(FRAME_LEN+1).

## Timing
- Latency: a bit accepted at edge t gives d_out/valid_o/sof_o valid after edge t. Outputs are registered, so latency is 1 cycle.
- With enable_i held high, one frame takes FRAME_LEN+K-1 cycles. ready_o drops the cycle after the last data bit is accepted. The first bit of the next frame is accepted on the cycle after the eof_o symbol.
- Reset:
  - valid_o=0, d_out=0, sof_o=0, eof_o=0, frame_ct_o=0, ready_o=1.
  - sr=0, counters 0, state IDLE.
- Reset mid-frame or mid-tail: the partial frame is dropped, no eof_o is produced, and frame_ct_o is cleared.
- A bit presented while ready_o=0 is not consumed. The source must hold it until ready_o=1.

## Configuration
- ENC_TAIL_EN defined: behaviour as above, with TAIL state and zero-flush.
- ENC_TAIL_EN undefined: no TAIL state and ready_o tied to 1. sr is never cleared except by reset, so encoding is continuous across frames.
  - sof_o marks data bit 1 of each FRAME_LEN-bit group.
  - eof_o marks data bit FRAME_LEN; frame_ct_o increments there.
  - One frame takes FRAME_LEN cycles.

## Structure
- Package conv_enc_pkg holds:
  - the state enum typedef (IDLE, DATA, TAIL)
  - default K, G0 and G1 constants
  - the parity function
- One sub-module, conv_enc_core: holds sr, with a shift/clear control and a combinational parity symbol output. The FSM, counters and output registers live in conv_enc_framer.

## Test plan
- FRAME_LEN=4, ENC_TAIL_EN, enable_i continuous, d_in=1,0,1,1 -> d_out 11,10,00,01,01,11 on 6 consecutive cycles; sof_o on the first, eof_o on the last; frame_ct_o=1; ready_o low for exactly the 2 tail cycles.
- Impulse: FRAME_LEN=16, d_in=1 then 15 zeros -> 11,10,11, then 00 for the rest including tail; 18 symbols in total.
- Gapped input: FRAME_LEN=4, enable_i pattern 1,0,0,1,1,0,1 with bits 1,0,1,1 -> same 6 symbols as the first scenario; valid_o=0 in the gap cycles; encoder state unchanged across gaps.
- Back-pressure: enable_i held high through TAIL -> no bit consumed while ready_o=0; the next frame's first bit is accepted the cycle after eof_o, with sof_o=1.
- Reset mid-tail: assert rst during tail cycle 1 -> all outputs 0, ready_o=1, frame_ct_o=0; the next frame encodes from sr=0 (first 1 bit gives 11).
- ENC_TAIL_EN undefined, FRAME_LEN=4, 8 bits 1,0,1,1,0,0,0,0 -> 11,10,00,01,01,11,00,00; ready_o always 1; eof_o on symbols 4 and 8; frame_ct_o=2.
